// File: rtl/ctrl_edicion_rtc.sv
// Edit-sequencing controller: selects time/date/timer mode, captures the
// three selected BCD fields, lets the user edit them with wrap-around and
// hands the result to the RTC write port through a req/ack handshake.
module ctrl_edicion_rtc #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_hora,
  input  logic         btn_fecha,
  input  logic         btn_timer,
  input  logic         btn_izq,
  input  logic         btn_der,
  input  logic         btn_arriba,
  input  logic         btn_abajo,
  input  logic         btn_ok,
  input  logic [N-1:0] dato_1_in,
  input  logic [N-1:0] dato_2_in,
  input  logic [N-1:0] dato_3_in,
  input  logic         wr_ack,
  output logic         f1,
  output logic         f2,
  output logic         f3,
  output logic [1:0]   cursor,
  output logic [N-1:0] dato_1_out,
  output logic [N-1:0] dato_2_out,
  output logic [N-1:0] dato_3_out,
  output logic         wr_req,
  output logic         busy
);

  localparam int unsigned D  = 4;        // BCD digit width
  localparam int unsigned NF = 3;        // number of edited fields

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EDIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  state_t         r_state;
  logic [2:0]     r_f;                   // {f3, f2, f1}
  logic [1:0]     r_cursor;
  logic [N-1:0]   r_dat [NF];
  logic           r_wr_req;
  logic           r_busy;

  state_t         w_state_nxt;
  logic [2:0]     w_f_nxt;
  logic [1:0]     w_cursor_nxt;
  logic [N-1:0]   w_dat_nxt [NF];
  logic           w_wr_req_nxt;

  logic [N-1:0]   w_din  [NF];
  logic [N-1:0]   w_min  [NF];
  logic [N-1:0]   w_max  [NF];
  logic [N-1:0]   w_inc  [NF];
  logic [N-1:0]   w_dec  [NF];
  logic           w_date;
  logic           w_own;

  // Replace non-BCD or out-of-range captures by the field minimum
  function automatic logic [N-1:0] fn_sanitize(input logic [N-1:0] v,
                                               input logic [N-1:0] mn,
                                               input logic [N-1:0] mx);
    logic bad;
    bad = (v[D-1:0] > D'(9)) || (v[N-1:D] > (N-D)'(9)) || (v < mn) || (v > mx);
    return bad ? mn : v;
  endfunction

  // BCD increment with max -> min wrap
  function automatic logic [N-1:0] fn_inc(input logic [N-1:0] v,
                                          input logic [N-1:0] mn,
                                          input logic [N-1:0] mx);
    logic [N-1:0] res;
    if (v >= mx)
      res = mn;
    else if (v[D-1:0] == D'(9))
      res = {v[N-1:D] + (N-D)'(1), D'(0)};
    else
      res = v + N'(1);
    return res;
  endfunction

  // BCD decrement with min -> max wrap
  function automatic logic [N-1:0] fn_dec(input logic [N-1:0] v,
                                          input logic [N-1:0] mn,
                                          input logic [N-1:0] mx);
    logic [N-1:0] res;
    if (v <= mn)
      res = mx;
    else if (v[D-1:0] == D'(0))
      res = {v[N-1:D] - (N-D)'(1), D'(9)};
    else
      res = v - N'(1);
    return res;
  endfunction

  assign w_din[0] = dato_1_in;
  assign w_din[1] = dato_2_in;
  assign w_din[2] = dato_3_in;
  assign w_date   = r_f[1];
  assign w_own    = (r_f[0] & btn_hora) | (r_f[1] & btn_fecha) | (r_f[2] & btn_timer);

  // Field ranges for the active mode and the candidate edited values
  always_comb begin
    w_min[0] = w_date ? N'('h01) : N'('h00);
    w_max[0] = w_date ? N'('h31) : N'('h23);
    w_min[1] = w_date ? N'('h01) : N'('h00);
    w_max[1] = w_date ? N'('h12) : N'('h59);
    w_min[2] = N'('h00);
    w_max[2] = w_date ? N'('h99) : N'('h59);
    for (int i = 0; i < NF; i++) begin
      w_inc[i] = fn_inc(r_dat[i], w_min[i], w_max[i]);
      w_dec[i] = fn_dec(r_dat[i], w_min[i], w_max[i]);
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state_nxt  = r_state;
    w_f_nxt      = r_f;
    w_cursor_nxt = r_cursor;
    w_wr_req_nxt = r_wr_req;
    for (int i = 0; i < NF; i++) w_dat_nxt[i] = r_dat[i];

    unique case (r_state)
      ST_IDLE: begin
        if (btn_hora) begin
          w_f_nxt     = 3'b001;
          w_state_nxt = ST_LOAD;
        end else if (btn_fecha) begin
          w_f_nxt     = 3'b010;
          w_state_nxt = ST_LOAD;
        end else if (btn_timer) begin
          w_f_nxt     = 3'b100;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < NF; i++)
          w_dat_nxt[i] = fn_sanitize(w_din[i], w_min[i], w_max[i]);
        w_cursor_nxt = 2'd0;
        w_state_nxt  = ST_EDIT;
      end
      ST_EDIT: begin
        if (w_own) begin
          w_f_nxt     = 3'b000;
          w_state_nxt = ST_IDLE;
        end else if (btn_ok) begin
          w_wr_req_nxt = 1'b1;
          w_state_nxt  = ST_WRITE;
        end else if (btn_der) begin
          w_cursor_nxt = (r_cursor == 2'd2) ? 2'd0 : r_cursor + 2'd1;
        end else if (btn_izq) begin
          w_cursor_nxt = (r_cursor == 2'd0) ? 2'd2 : r_cursor - 2'd1;
        end else if (btn_arriba || btn_abajo) begin
          for (int i = 0; i < NF; i++)
            if (r_cursor == 2'(i))
              w_dat_nxt[i] = btn_arriba ? w_inc[i] : w_dec[i];
        end
      end
      ST_WRITE: begin
        w_wr_req_nxt = 1'b1;
        if (wr_ack) begin
          w_wr_req_nxt = 1'b0;
          w_f_nxt      = 3'b000;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_f      <= 3'b000;
      r_cursor <= 2'd0;
      r_wr_req <= 1'b0;
      r_busy   <= 1'b0;
      for (int i = 0; i < NF; i++) r_dat[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_f      <= w_f_nxt;
      r_cursor <= w_cursor_nxt;
      r_wr_req <= w_wr_req_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      for (int i = 0; i < NF; i++) r_dat[i] <= w_dat_nxt[i];
    end
  end

  assign f1         = r_f[0];
  assign f2         = r_f[1];
  assign f3         = r_f[2];
  assign cursor     = r_cursor;
  assign dato_1_out = r_dat[0];
  assign dato_2_out = r_dat[1];
  assign dato_3_out = r_dat[2];
  assign wr_req     = r_wr_req;
  assign busy       = r_busy;

endmodule

// File: doc/ctrl_edicion_rtc.md
Name: ctrl_edicion_rtc

Overview:
Edit-sequencing controller for the time/date/timer output selector and the RTC write path. It decodes debounced push-button pulses into one of three edit modes and drives the selector flags f1/f2/f3. It captures the three selected values, lets the user move a cursor and increment or decrement each BCD field with range wrap-around, and hands the edited triple to the RTC interface through a req/ack handshake.

Parameters:
N, 8, width of each data field (two BCD digits).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_hora  input  1  one-cycle pulse: enter/cancel time edit
btn_fecha  input  1  one-cycle pulse: enter/cancel date edit
btn_timer  input  1  one-cycle pulse: enter/cancel timer edit
btn_izq  input  1  one-cycle pulse: cursor left
btn_der  input  1  one-cycle pulse: cursor right
btn_arriba  input  1  one-cycle pulse: increment field at cursor
btn_abajo  input  1  one-cycle pulse: decrement field at cursor
btn_ok  input  1  one-cycle pulse: commit edit
dato_1_in, dato_2_in, dato_3_in  input  N each  current values from the output selector (hh/mm/ss or dd/mm/yy)
wr_ack  input  1  RTC interface accepted the write
f1, f2, f3  output  1 each  selector flags: time, date, timer (one-hot or all zero)
cursor  output  2  field being edited: 0 = dato_1, 1 = dato_2, 2 = dato_3
dato_1_out, dato_2_out, dato_3_out  output  N each  edited values (BCD)
wr_req  output  1  write request to the RTC interface
busy  output  1  high in any state except IDLE

Behaviour:
- The clock and reset are fixed: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset, and any cycle with reset high (including mid-edit or mid-write): state = IDLE, f1 = f2 = f3 = 0, cursor = 0, dato_x_out = 0x00, wr_req = 0, busy = 0.
- IDLE:
  - btn_hora sets f1, btn_fecha sets f2, btn_timer sets f3, then go to LOAD.
  - Priority when pulses coincide: hora > fecha > timer.
  - All other buttons are ignored in IDLE.
- LOAD (exactly 1 cycle; lets the selector settle on the new flag):
  - Capture dato_1_in..dato_3_in into dato_x_out, set cursor = 0, go to EDIT.
  - Any captured field that is not valid BCD or is outside its range is replaced by that field's minimum.
- EDIT: at most one action per cycle. Priority: own-mode button > btn_ok > btn_izq/btn_der > btn_arriba/btn_abajo.
  - Own-mode button (the one that entered this mode): cancel. Flags clear, go to IDLE, no write. Other mode buttons are ignored.
  - btn_ok: go to WRITE; the flag stays asserted.
  - btn_der: cursor 0→1→2→0. btn_izq: 0→2→1→0. If both are pulsed together, btn_der wins.
  - btn_arriba: BCD increment of the field at cursor; max wraps to min.
  - btn_abajo: BCD decrement; min wraps to max. If both are pulsed together, btn_arriba wins.
  - BCD rule: the low digit rolls 9→0 with carry into the high digit; results never hold A–F nibbles. Example: 0x19+1 = 0x20, 0x20−1 = 0x19.
- Field ranges (BCD):
  - f1 or f3: dato_1 00–23, dato_2 00–59, dato_3 00–59.
  - f2: dato_1 01–31, dato_2 01–12, dato_3 00–99.
  - Day range is fixed at 01–31; month-length checking is not done here.
- WRITE:
  - wr_req is asserted on the cycle after entry and held high, with dato_x_out stable, until wr_ack is sampled high.
  - The cycle after wr_ack is sampled: wr_req = 0, flags clear, go to IDLE.
  - All buttons are ignored in WRITE. There is no timeout.
  - wr_ack received outside WRITE is ignored.
- The f1..f3 flags are registered and one-hot when nonzero. busy = (state != IDLE).
- dato_x_out holds its last value in IDLE; it is not cleared after a write.

Test Plan:
- Reset mid-WRITE (wr_req = 1), pulse reset 1 cycle -> next cycle wr_req = 0, f1..f3 = 0, dato_x_out = 0x00, busy = 0.
- Time edit with wrap: btn_hora, inputs 23/59/30.
  - Expect f1 = 1, then LOAD captures 0x23/0x59/0x30.
  - btn_arriba -> dato_1_out = 0x00.
  - btn_der, btn_arriba -> dato_2_out = 0x00.
  - btn_der, btn_abajo twice -> dato_3_out = 0x28.
- Date edit with lower bounds: btn_fecha, inputs 01/01/00.
  - btn_abajo -> dato_1_out = 0x31.
  - btn_der, btn_abajo -> dato_2_out = 0x12.
  - btn_izq twice -> cursor = 2; btn_abajo -> dato_3_out = 0x99.
- Commit handshake: EDIT, btn_ok -> wr_req = 1 held with data stable while wr_ack = 0 for 5 cycles.
  - Raise wr_ack -> wr_req = 0 and f2 = 0 the next cycle, busy = 0.
- Cancel and priority:
  - btn_timer then btn_timer again -> IDLE, no wr_req ever.
  - In IDLE, btn_hora and btn_fecha together -> f1 = 1 only.
  - In EDIT, btn_ok and btn_arriba together -> WRITE, field unchanged.
- Invalid load: btn_hora with dato_1_in = 0x3F, dato_2_in = 0x75 -> dato_1_out = 0x00, dato_2_out = 0x00 after LOAD; btn_arriba -> dato_1_out = 0x01.
